// File: rtl/sequence_generator_pkg.sv
// Shared types and constants for the sequence generator: FSM encoding, LFSR
// taps, difficulty codes, digit ranges and the digit-mapping helpers.
package seqgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] DIFF_EASY = 2'b01;
  localparam logic [1:0] DIFF_MED  = 2'b10;
  localparam logic [1:0] DIFF_HARD = 2'b11;

  localparam int DEF_DEPTH = 32;
  localparam int DEF_AW    = 5;

  localparam logic [3:0] RANGE_EASY = 4'd4;
  localparam logic [3:0] RANGE_MED  = 4'd8;
  localparam logic [3:0] RANGE_HARD = 4'd10;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] digit_map(input logic [3:0] v, input logic [1:0] diff);
    case (diff)
      DIFF_MED:  return {1'b0, v[2:0]};
      DIFF_HARD: return (v >= 4'd10) ? (v - 4'd10) : v;
      default:   return {2'b00, v[1:0]};
    endcase
  endfunction

  function automatic logic [3:0] digit_limit(input logic [1:0] diff);
    case (diff)
      DIFF_MED:  return RANGE_MED;
      DIFF_HARD: return RANGE_HARD;
      default:   return RANGE_EASY;
    endcase
  endfunction

endpackage

// File: rtl/sequence_generator_if.sv
// Request/status and RAM write bus between the sequence generator (slave)
// and the game controller that requests fills (master).
interface seqgen_if #(
  parameter int AW = 5
);
  logic          GoGen;
  logic [1:0]    Diff;
  logic          RAMWrEn;
  logic [AW-1:0] RAMWrAddr;
  logic [3:0]    RAMWrData;
  logic          Busy;
  logic          FinGen;

  modport master (
    output GoGen, Diff,
    input  RAMWrEn, RAMWrAddr, RAMWrData, Busy, FinGen
  );

  modport slave (
    input  GoGen, Diff,
    output RAMWrEn, RAMWrAddr, RAMWrData, Busy, FinGen
  );
endinterface

// File: rtl/sequence_generator_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and advance enable; load wins
// over enable.
module lfsr16
  import seqgen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_VAL = 16'h0001
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              en_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] load_val_i,
  output logic [LFSR_W-1:0] state_o
);
  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = load_val_i;
    end else if (en_i) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
endmodule

// File: rtl/sequence_generator.sv
// Fills the sequence RAM with DEPTH pseudo-random digits per GoGen request.
// Optional macro SEQGEN_NO_REPEAT_EN bumps a digit that repeats its predecessor.
module sequence_generator
  import seqgen_pkg::*;
#(
  parameter int                DEPTH = DEF_DEPTH,
  parameter int                AW    = DEF_AW,
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
  input  logic     Clk,
  input  logic     Rst,
  seqgen_if.slave  bus
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [1:0]        diff_q, diff_d;
  logic [LFSR_W-1:0] ent_q, gen_q, gen_next, seed_val;
  logic              gen_load, gen_en;
  logic [3:0]        digit;
  logic              wr_en_q, wr_en_d, busy_q, busy_d, fin_q, fin_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [3:0]        data_q, data_d;
`ifdef SEQGEN_NO_REPEAT_EN
  logic [3:0]        prev_q, prev_d;
`endif

  // Entropy source free-runs so the seed depends on when GoGen arrives
  lfsr16 #(.RESET_VAL(SEED)) u_entropy (
    .Clk(Clk), .Rst(Rst), .en_i(1'b1), .load_i(1'b0),
    .load_val_i('0), .state_o(ent_q)
  );

  lfsr16 #(.RESET_VAL(16'h0001)) u_gen (
    .Clk(Clk), .Rst(Rst), .en_i(gen_en), .load_i(gen_load),
    .load_val_i(seed_val), .state_o(gen_q)
  );

  assign seed_val = (ent_q == '0) ? 16'h0001 : ent_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    gen_load = 1'b0;
    gen_en   = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.GoGen) state_d = ST_SEED;
      ST_SEED: begin
        gen_load = 1'b1;
        diff_d   = (bus.Diff == 2'b00) ? DIFF_EASY : bus.Diff;
        cnt_d    = '0;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        gen_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from next-cycle values
    gen_next = gen_load ? seed_val : (gen_en ? lfsr_step(gen_q) : gen_q);
    digit    = digit_map(gen_next[3:0], diff_d);
`ifdef SEQGEN_NO_REPEAT_EN
    if (cnt_d != '0 && digit == prev_q) begin
      digit = ((digit + 4'd1) == digit_limit(diff_d)) ? 4'd0 : (digit + 4'd1);
    end
`endif

    wr_en_d = (state_d == ST_WRITE);
    addr_d  = wr_en_d ? cnt_d : '0;
    data_d  = wr_en_d ? digit : 4'd0;
    busy_d  = (state_d != ST_IDLE);
    fin_d   = (state_d == ST_DONE);
`ifdef SEQGEN_NO_REPEAT_EN
    prev_d = prev_q;
    if (state_q == ST_SEED) prev_d = 4'd0;
    if (wr_en_d) prev_d = digit;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      diff_q  <= DIFF_EASY;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= 4'd0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
`ifdef SEQGEN_NO_REPEAT_EN
      prev_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
`ifdef SEQGEN_NO_REPEAT_EN
      prev_q  <= prev_d;
`endif
    end
  end

  assign bus.RAMWrEn   = wr_en_q;
  assign bus.RAMWrAddr = addr_q;
  assign bus.RAMWrData = data_q;
  assign bus.Busy      = busy_q;
  assign bus.FinGen    = fin_q;
endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: per-cycle history of the bus is
// recorded and each fill is checked against hand-derived timing and ranges.
// Also exercises SEQGEN_NO_REPEAT_EN when that macro is defined.
module tb_sequence_generator;
  localparam int HN = 4096;

  logic Clk = 1'b0;
  logic Rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  seqgen_if #(.AW(5)) bus ();

  sequence_generator #(.DEPTH(32), .AW(5), .SEED(16'hACE1)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  logic       h_wr   [HN];
  logic       h_busy [HN];
  logic       h_fin  [HN];
  logic [4:0] h_addr [HN];
  logic [3:0] h_data [HN];
  int         last_seq [32];
  int         seq_a [32];

  always @(negedge Clk) begin
    if (cyc < HN) begin
      h_wr[cyc]   <= bus.RAMWrEn;
      h_busy[cyc] <= bus.Busy;
      h_fin[cyc]  <= bus.FinGen;
      h_addr[cyc] <= bus.RAMWrAddr;
      h_data[cyc] <= bus.RAMWrData;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_to(input int n);
    int budget = 0;
    while (cyc < n && budget < 20000) begin
      @(negedge Clk);
      budget++;
    end
    if (cyc < n) chk("wait_timeout", cyc, n);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  // GoGen is high during cycle t; returns t
  task automatic start_fill(input logic [1:0] d, output int t);
    @(negedge Clk);
    bus.Diff  = d;
    bus.GoGen = 1'b1;
    t = cyc;
    @(negedge Clk);
    bus.GoGen = 1'b0;
  endtask

  task automatic check_fill(input string tag, input int t, input int maxv);
    int nwr = 0, bad_wr = 0, bad_busy = 0, bad_fin = 0, over = 0, zeros = 0;
    for (int k = 1; k <= 35; k++) begin
      int  idx = t + k;
      bit  exp_wr = (k >= 2 && k <= 33);
      if (h_wr[idx] !== exp_wr) bad_wr++;
      else if (exp_wr && int'(h_addr[idx]) != k - 2) bad_wr++;
      if (h_wr[idx] === 1'b1) begin
        if (nwr < 32) last_seq[nwr] = int'(h_data[idx]);
        nwr++;
        if (int'(h_data[idx]) > maxv) over++;
        if (h_data[idx] == 4'd0) zeros++;
      end
      if (h_busy[idx] !== (k <= 34)) bad_busy++;
      if (h_fin[idx] !== (k == 34)) bad_fin++;
    end
    chk({tag, "_writes"}, nwr, 32);
    chk({tag, "_wr_addr"}, bad_wr, 0);
    chk({tag, "_busy"}, bad_busy, 0);
    chk({tag, "_fin"}, bad_fin, 0);
    chk({tag, "_range"}, over, 0);
    chk({tag, "_allzero"}, int'(zeros == 32), 0);
    $display("fill %s t=%0d writes=%0d first=%0d last=%0d", tag, t, nwr, last_seq[0], last_seq[31]);
  endtask

  initial begin
    int t, t2, ndiff, nwr, nfin;
    Rst = 1'b1;
    bus.GoGen = 1'b0;
    bus.Diff  = 2'b01;
    repeat (3) @(negedge Clk);
    chk("rst_wren", int'(bus.RAMWrEn), 0);
    chk("rst_addr", int'(bus.RAMWrAddr), 0);
    chk("rst_data", int'(bus.RAMWrData), 0);
    chk("rst_busy", int'(bus.Busy), 0);
    chk("rst_fin", int'(bus.FinGen), 0);
    Rst = 1'b0;
    repeat (6) @(negedge Clk);

    start_fill(2'b11, t); wait_to(t + 37); check_fill("hard", t, 9);
    start_fill(2'b01, t); wait_to(t + 37); check_fill("easy", t, 3);
    // Diff moves to hard mid-fill; the latched medium range must hold
    start_fill(2'b10, t);
    repeat (5) @(negedge Clk);
    bus.Diff = 2'b11;
    wait_to(t + 37); check_fill("med", t, 7);

    do_reset(); repeat (5) @(negedge Clk);
    start_fill(2'b01, t); wait_to(t + 37); check_fill("d01", t, 3);
    for (int i = 0; i < 32; i++) seq_a[i] = last_seq[i];
    do_reset(); repeat (5) @(negedge Clk);
    start_fill(2'b00, t); wait_to(t + 37); check_fill("d00", t, 3);
    ndiff = 0;
    for (int i = 0; i < 32; i++) if (seq_a[i] != last_seq[i]) ndiff++;
    chk("d00_eq_d01", ndiff, 0);

    do_reset(); repeat (3) @(negedge Clk);
    start_fill(2'b11, t); wait_to(t + 37); check_fill("delay3", t, 9);
    for (int i = 0; i < 32; i++) seq_a[i] = last_seq[i];
    do_reset(); repeat (7) @(negedge Clk);
    start_fill(2'b11, t); wait_to(t + 37); check_fill("delay7", t, 9);
    ndiff = 0;
    for (int i = 0; i < 32; i++) if (seq_a[i] != last_seq[i]) ndiff++;
    chk("delays_differ", int'(ndiff > 0), 1);

    // GoGen held for 40 cycles: one fill, then a second from re-entered IDLE
    @(negedge Clk);
    bus.Diff = 2'b11; bus.GoGen = 1'b1; t = cyc;
    repeat (40) @(negedge Clk);
    bus.GoGen = 1'b0;
    wait_to(t + 73);
    nwr = 0; nfin = 0;
    for (int k = 1; k <= 35; k++) begin
      if (h_wr[t + k] === 1'b1) nwr++;
      if (h_fin[t + k] === 1'b1) nfin++;
    end
    chk("held_first_writes", nwr, 32);
    chk("held_first_fin", nfin, 1);
    chk("held_idle_gap", int'(h_busy[t + 35]), 0);
    chk("held_restart_busy", int'(h_busy[t + 36]), 1);
    chk("held_second_addr0", int'(h_wr[t + 37] === 1'b1 && h_addr[t + 37] == 5'd0), 1);
    nwr = 0; nfin = 0;
    for (int k = 1; k <= 71; k++) begin
      if (h_wr[t + k] === 1'b1) nwr++;
      if (h_fin[t + k] === 1'b1) nfin++;
    end
    chk("held_total_writes", nwr, 64);
    chk("held_total_fin", nfin, 2);
    $display("held GoGen t=%0d writes=%0d fins=%0d", t, nwr, nfin);

    // Reset asserted during the 10th write (cycle t+11)
    start_fill(2'b10, t);
    wait_to(t + 11);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    wait_to(t + 32);
    nwr = 0; nfin = 0;
    for (int k = 1; k <= 11; k++) if (h_wr[t + k] === 1'b1) nwr++;
    for (int k = 12; k <= 30; k++) if (h_fin[t + k] === 1'b1 || h_busy[t + k] === 1'b1) nfin++;
    chk("rstmid_writes", nwr, 10);
    chk("rstmid_wren", int'(h_wr[t + 12]), 0);
    chk("rstmid_busy", int'(h_busy[t + 12]), 0);
    chk("rstmid_quiet", nfin, 0);
    $display("mid-fill reset t=%0d writes_before=%0d", t, nwr);
    start_fill(2'b11, t); wait_to(t + 37); check_fill("after_rst", t, 9);

`ifdef SEQGEN_NO_REPEAT_EN
    begin
      int rep = 0, over = 0;
      for (int f = 0; f < 50; f++) begin
        repeat (f % 5) @(negedge Clk);
        start_fill(2'b01, t2);
        wait_to(t2 + 37);
        for (int k = 2; k <= 33; k++) begin
          if (h_data[t2 + k] > 4'd3) over++;
          if (k >= 3 && h_data[t2 + k] == h_data[t2 + k - 1]) rep++;
        end
        $display("norep fill %0d t=%0d", f, t2);
      end
      chk("norep_repeats", rep, 0);
      chk("norep_range", over, 0);
    end
`else
    t2 = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
